// File: rtl/rare_net_monitor_pkg.sv
// rtl/rare_net_monitor_pkg.sv - shared types, defaults and rarity helper for the rare-net monitor
package rare_net_monitor_pkg;

    localparam int DEF_CNT_W       = 16;
    localparam int DEF_RARE_THRESH = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_REPORT = 2'd2
    } state_e;

    // A window is rare when either polarity was seen at most thresh times.
    function automatic logic is_rare(input int unsigned ones,
                                     input int unsigned len,
                                     input int unsigned thresh);
        return (ones <= thresh) || ((len - ones) <= thresh);
    endfunction

endpackage

// File: rtl/rare_net_monitor_if.sv
// rtl/rare_net_monitor_if.sv - control, sample and report signals of the rare-net monitor
interface rare_net_monitor_if
    import rare_net_monitor_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             net_in;
    logic             start;
    logic [CNT_W-1:0] window_len;
    logic             rpt_ready;
    logic             busy;
    logic             rpt_valid;
    logic [CNT_W-1:0] ones_cnt;
    logic [CNT_W-1:0] toggle_cnt;
    logic             rare_flag;
    logic             overflow;

    modport master (
        output net_in, start, window_len, rpt_ready,
        input  busy, rpt_valid, ones_cnt, toggle_cnt, rare_flag, overflow
    );

    modport slave (
        input  net_in, start, window_len, rpt_ready,
        output busy, rpt_valid, ones_cnt, toggle_cnt, rare_flag, overflow
    );
endinterface

// File: rtl/rare_net_monitor_sat_counter.sv
// rtl/rare_net_monitor_sat_counter.sv - saturating up-counter with clear and at-max flag
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             sat
);
    localparam logic [CNT_W-1:0] MAX_VAL = '1;

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != MAX_VAL)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign sat   = (count_q == MAX_VAL);

endmodule

// File: rtl/rare_net_monitor.sv
// rtl/rare_net_monitor.sv - counts ones and toggles of a net over a window and flags rare activity
module rare_net_monitor
    import rare_net_monitor_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int RARE_THRESH = DEF_RARE_THRESH
) (
    input logic               I1470_clk,
    input logic               I1477_rst,
    rare_net_monitor_if.slave mon
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             rare_vld_q, rare_vld_d;
    logic             prev_net_q, prev_net_d;

    logic             cnt_clr;
    logic             sample;
    logic             ones_inc, tog_inc;
    logic             ones_sat, tog_sat;
    logic [CNT_W-1:0] ones_cnt, toggle_cnt;

    assign prev_net_d = mon.net_in;
    assign sample     = (state_q == ST_RUN);
    assign ones_inc   = sample & mon.net_in;
    assign tog_inc    = sample & (mon.net_in ^ prev_net_q);

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        rem_d      = rem_q;
        rare_vld_d = rare_vld_q;
        cnt_clr    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mon.start) begin
                    cnt_clr    = 1'b1;
                    len_d      = mon.window_len;
                    rem_d      = mon.window_len;
                    // An empty window has no samples, so it reports immediately as rare.
                    if (mon.window_len == '0) begin
                        rare_vld_d = 1'b1;
                        state_d    = ST_REPORT;
                    end else begin
                        rare_vld_d = 1'b0;
                        state_d    = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                rem_d = rem_q - 1'b1;
                if (rem_q == CNT_W'(1)) begin
                    rare_vld_d = 1'b1;
                    state_d    = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (mon.rpt_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge I1470_clk) begin
        if (I1477_rst) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            rem_q      <= '0;
            rare_vld_q <= 1'b0;
            prev_net_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            rem_q      <= rem_d;
            rare_vld_q <= rare_vld_d;
            prev_net_q <= prev_net_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_ones_cnt (
        .clk   (I1470_clk),
        .rst   (I1477_rst),
        .clr   (cnt_clr),
        .inc   (ones_inc),
        .count (ones_cnt),
        .sat   (ones_sat)
    );

    sat_counter #(.CNT_W(CNT_W)) u_toggle_cnt (
        .clk   (I1470_clk),
        .rst   (I1477_rst),
        .clr   (cnt_clr),
        .inc   (tog_inc),
        .count (toggle_cnt),
        .sat   (tog_sat)
    );

    // Counters only move up between clears, so an at-max counter marks overflow until the next start.
    assign mon.busy       = (state_q != ST_IDLE);
    assign mon.rpt_valid  = (state_q == ST_REPORT);
    assign mon.ones_cnt   = ones_cnt;
    assign mon.toggle_cnt = toggle_cnt;
    assign mon.rare_flag  = rare_vld_q & is_rare(32'(ones_cnt), 32'(len_q), RARE_THRESH);
    assign mon.overflow   = ones_sat | tog_sat;

endmodule

// File: tb/tb_rare_net_monitor.sv
// tb/tb_rare_net_monitor.sv - table-driven scoreboard bench for rare_net_monitor
module tb_rare_net_monitor;

    typedef struct {
        string       name;
        bit          sel;
        int          len;
        bit          prev;
        logic [31:0] bits;
        int          hold;
        logic [15:0] e_ones;
        logic [15:0] e_tog;
        logic        e_rare;
        logic        e_ovf;
    } vec_t;

    typedef struct {
        logic [15:0] ones;
        logic [15:0] tog;
        logic        rare;
        logic        ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sc_clr = 1'b0;
    logic       sc_inc = 1'b0;
    logic [3:0] sc_count;
    logic       sc_sat;
    int         n_tests = 0;
    int         n_fail = 0;
    exp_t       sb_q[$];
    vec_t       vecs[$];

    always #5 clk = ~clk;

    rare_net_monitor_if #(.CNT_W(16)) bus();
    rare_net_monitor_if #(.CNT_W(4))  bus4();

    rare_net_monitor #(.CNT_W(16), .RARE_THRESH(2)) u_dut (
        .I1470_clk (clk),
        .I1477_rst (rst),
        .mon       (bus)
    );

    rare_net_monitor #(.CNT_W(4), .RARE_THRESH(2)) u_dut4 (
        .I1470_clk (clk),
        .I1477_rst (rst),
        .mon       (bus4)
    );

    sat_counter #(.CNT_W(4)) u_sat (
        .clk   (clk),
        .rst   (rst),
        .clr   (sc_clr),
        .inc   (sc_inc),
        .count (sc_count),
        .sat   (sc_sat)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] o_ones(input bit s);
        return s ? {12'd0, bus4.ones_cnt} : bus.ones_cnt;
    endfunction
    function automatic logic [15:0] o_tog(input bit s);
        return s ? {12'd0, bus4.toggle_cnt} : bus.toggle_cnt;
    endfunction
    function automatic logic o_valid(input bit s);
        return s ? bus4.rpt_valid : bus.rpt_valid;
    endfunction
    function automatic logic o_busy(input bit s);
        return s ? bus4.busy : bus.busy;
    endfunction
    function automatic logic o_rare(input bit s);
        return s ? bus4.rare_flag : bus.rare_flag;
    endfunction
    function automatic logic o_ovf(input bit s);
        return s ? bus4.overflow : bus.overflow;
    endfunction

    task automatic drive(input bit s, input logic n, input logic st, input int len, input logic rdy);
        if (s) begin
            bus4.net_in = n; bus4.start = st; bus4.window_len = 4'(len); bus4.rpt_ready = rdy;
        end else begin
            bus.net_in = n; bus.start = st; bus.window_len = 16'(len); bus.rpt_ready = rdy;
        end
    endtask

    task automatic run_window(input vec_t v);
        exp_t e;
        exp_t got;
        bit   early;
        bit   stable;
        int   wait_n;
        e = '{v.e_ones, v.e_tog, v.e_rare, v.e_ovf};
        @(negedge clk);
        drive(v.sel, v.prev, 1'b1, v.len, 1'b0);
        sb_q.push_back(e);
        early = 1'b0;
        for (int k = 0; k < v.len; k++) begin
            @(negedge clk);
            if (o_valid(v.sel) || !o_busy(v.sel)) early = 1'b1;
            drive(v.sel, v.bits[k], 1'b0, v.len, 1'b0);
        end
        @(negedge clk);
        drive(v.sel, 1'b0, 1'b0, 0, 1'b0);
        chk({v.name, ":no_early_valid"}, 32'(early), 32'd0);
        chk({v.name, ":latency"}, 32'(o_valid(v.sel)), 32'd1);
        wait_n = 0;
        while (!o_valid(v.sel) && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        got = sb_q.pop_front();
        if (!o_valid(v.sel)) begin
            chk({v.name, ":report_timeout"}, 32'd0, 32'd1);
            return;
        end
        chk({v.name, ":ones_cnt"}, 32'(o_ones(v.sel)), 32'(got.ones));
        chk({v.name, ":toggle_cnt"}, 32'(o_tog(v.sel)), 32'(got.tog));
        chk({v.name, ":rare_flag"}, 32'(o_rare(v.sel)), 32'(got.rare));
        chk({v.name, ":overflow"}, 32'(o_ovf(v.sel)), 32'(got.ovf));
        stable = 1'b1;
        for (int h = 0; h < v.hold; h++) begin
            drive(v.sel, 1'b0, 1'b1, 3, 1'b0);
            @(negedge clk);
            if (!o_valid(v.sel) || o_ones(v.sel) !== got.ones || o_tog(v.sel) !== got.tog ||
                o_rare(v.sel) !== got.rare) stable = 1'b0;
        end
        if (v.hold > 0) chk({v.name, ":held_stable"}, 32'(stable), 32'd1);
        drive(v.sel, 1'b0, v.hold > 0, 3, 1'b1);
        @(negedge clk);
        chk({v.name, ":idle_busy"}, 32'(o_busy(v.sel)), 32'd0);
        chk({v.name, ":idle_valid"}, 32'(o_valid(v.sel)), 32'd0);
        chk({v.name, ":idle_ones_kept"}, 32'(o_ones(v.sel)), 32'(got.ones));
        chk({v.name, ":idle_rare_kept"}, 32'(o_rare(v.sel)), 32'(got.rare));
        drive(v.sel, 1'b0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen_valid;
        vecs.push_back('{"t1_prev1",   1'b0,  8, 1'b1, 32'h00AA, 0, 16'd4,  16'd8,  1'b0, 1'b0});
        vecs.push_back('{"t1_prev0",   1'b0,  8, 1'b0, 32'h00AA, 0, 16'd4,  16'd7,  1'b0, 1'b0});
        vecs.push_back('{"t2_single",  1'b0, 10, 1'b0, 32'h0004, 0, 16'd1,  16'd2,  1'b1, 1'b0});
        vecs.push_back('{"t3_len0",    1'b0,  0, 1'b0, 32'h0000, 0, 16'd0,  16'd0,  1'b1, 1'b0});
        vecs.push_back('{"all_ones",   1'b0,  5, 1'b0, 32'h001F, 0, 16'd5,  16'd1,  1'b1, 1'b0});
        vecs.push_back('{"mid3",       1'b0,  6, 1'b0, 32'h0007, 0, 16'd3,  16'd2,  1'b0, 1'b0});
        vecs.push_back('{"ones_eq2",   1'b0,  3, 1'b0, 32'h0005, 0, 16'd2,  16'd3,  1'b1, 1'b0});
        vecs.push_back('{"zeros_eq2",  1'b0,  6, 1'b0, 32'h0027, 0, 16'd4,  16'd3,  1'b1, 1'b0});
        vecs.push_back('{"zeros_eq3",  1'b0,  7, 1'b0, 32'h0047, 0, 16'd4,  16'd3,  1'b0, 1'b0});
        vecs.push_back('{"t5_hold",    1'b0,  4, 1'b0, 32'h0006, 5, 16'd2,  16'd2,  1'b1, 1'b0});
        vecs.push_back('{"t4_toggle",  1'b1, 15, 1'b0, 32'h5555, 0, 16'd8,  16'd15, 1'b0, 1'b1});
        vecs.push_back('{"t4_ones",    1'b1, 15, 1'b1, 32'h7FFF, 0, 16'd15, 16'd0,  1'b1, 1'b1});
        vecs.push_back('{"t4_ovf_clr", 1'b1,  3, 1'b0, 32'h0000, 0, 16'd0,  16'd0,  1'b1, 1'b0});

        drive(1'b0, 1'b0, 1'b0, 0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 0, 1'b0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset:busy", 32'(bus.busy), 32'd0);
        chk("reset:rpt_valid", 32'(bus.rpt_valid), 32'd0);
        chk("reset:ones_cnt", 32'(bus.ones_cnt), 32'd0);
        chk("reset:toggle_cnt", 32'(bus.toggle_cnt), 32'd0);
        chk("reset:rare_flag", 32'(bus.rare_flag), 32'd0);
        chk("reset:overflow", 32'(bus.overflow), 32'd0);
        chk("reset:sat_count", 32'(sc_count), 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) run_window(vecs[i]);

        // Reset part-way through a window: two samples taken, reset lands on the third.
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 8, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 8, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 8, 1'b0);
        @(negedge clk);
        chk("t6:pre_reset_ones", 32'(bus.ones_cnt), 32'd2);
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 8, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 0, 1'b0);
        chk("t6:busy", 32'(bus.busy), 32'd0);
        chk("t6:rpt_valid", 32'(bus.rpt_valid), 32'd0);
        chk("t6:ones_cnt", 32'(bus.ones_cnt), 32'd0);
        chk("t6:toggle_cnt", 32'(bus.toggle_cnt), 32'd0);
        chk("t6:rare_flag", 32'(bus.rare_flag), 32'd0);
        chk("t6:overflow", 32'(bus.overflow), 32'd0);
        seen_valid = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.rpt_valid || bus.busy) seen_valid = 1'b1;
        end
        chk("t6:no_report", 32'(seen_valid), 32'd0);

        // Standalone counter: saturates at 15 and never wraps.
        sc_inc = 1'b1;
        repeat (14) @(negedge clk);
        chk("sat:count14", 32'(sc_count), 32'd14);
        chk("sat:flag14", 32'(sc_sat), 32'd0);
        repeat (6) @(negedge clk);
        chk("sat:count_held", 32'(sc_count), 32'd15);
        chk("sat:flag_set", 32'(sc_sat), 32'd1);
        sc_inc = 1'b0;
        sc_clr = 1'b1;
        @(negedge clk);
        sc_clr = 1'b0;
        chk("sat:cleared", 32'(sc_count), 32'd0);
        chk("sat:flag_clr", 32'(sc_sat), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
